// File: rtl/branch_resolver_pkg.sv
// ============================================================================
// Module   : branch_resolver_pkg
// Brief    : Shared flag positions, condition codes and FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_resolver_pkg;

    // Flag bit positions, identical to the ALU's {O,S,Z,C} word
    localparam int c_FLAG_O = 3;
    localparam int c_FLAG_S = 2;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_C = 0;

    localparam logic [3:0] c_COND_ALWAYS = 4'd0;
    localparam logic [3:0] c_COND_EQ     = 4'd1;
    localparam logic [3:0] c_COND_NE     = 4'd2;
    localparam logic [3:0] c_COND_MI     = 4'd3;
    localparam logic [3:0] c_COND_PL     = 4'd4;
    localparam logic [3:0] c_COND_CS     = 4'd5;
    localparam logic [3:0] c_COND_CC     = 4'd6;
    localparam logic [3:0] c_COND_VS     = 4'd7;
    localparam logic [3:0] c_COND_VC     = 4'd8;
    localparam logic [3:0] c_COND_GT     = 4'd9;
    localparam logic [3:0] c_COND_GE     = 4'd10;
    localparam logic [3:0] c_COND_LT     = 4'd11;
    localparam logic [3:0] c_COND_LE     = 4'd12;
    localparam logic [3:0] c_COND_HI     = 4'd13;
    localparam logic [3:0] c_COND_LS     = 4'd14;
    localparam logic [3:0] c_COND_NEVER  = 4'd15;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

endpackage

`default_nettype wire

// File: rtl/branch_resolver_bht.sv
// ============================================================================
// Module   : branch_resolver_bht
// Brief    : 2-bit saturating branch history table, async read, sync update.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolver_bht #(
    parameter int BHT_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BHT_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                wr_en,
    input  logic [BHT_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int c_ENTRIES = 1 << BHT_BITS;

    logic [1:0] r_ctr [c_ENTRIES];

    // Read sees the pre-update value when a write hits the same entry
    assign rd_ctr = r_ctr[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (wr_en) begin
            if (wr_taken && (r_ctr[wr_idx] != 2'b11)) begin
                r_ctr[wr_idx] <= r_ctr[wr_idx] + 2'b01;
            end else if (!wr_taken && (r_ctr[wr_idx] != 2'b00)) begin
                r_ctr[wr_idx] <= r_ctr[wr_idx] - 2'b01;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolver.sv
// ============================================================================
// Module   : branch_resolver
// Brief    : EX-stage branch resolution, BHT training, redirect and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int BHT_BITS     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  flags,
    input  logic        bubble,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [3:0]  br_cond,
    input  logic [15:0] br_pc,
    input  logic [15:0] br_imm,
    input  logic        br_pred_taken,
    input  logic [15:0] fetch_pc,
    output logic        fetch_pred_taken,
    output logic        redirect_valid,
    output logic [15:0] redirect_pc,
    output logic        flush,
    output logic [15:0] mispredict_count
);

    localparam logic [2:0] c_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] f);
        logic o, s, z, c;
        o = f[c_FLAG_O];
        s = f[c_FLAG_S];
        z = f[c_FLAG_Z];
        c = f[c_FLAG_C];
        case (cond)
            c_COND_ALWAYS: cond_taken = 1'b1;
            c_COND_EQ:     cond_taken = z;
            c_COND_NE:     cond_taken = !z;
            c_COND_MI:     cond_taken = s;
            c_COND_PL:     cond_taken = !s;
            c_COND_CS:     cond_taken = c;
            c_COND_CC:     cond_taken = !c;
            c_COND_VS:     cond_taken = o;
            c_COND_VC:     cond_taken = !o;
            c_COND_GT:     cond_taken = !z && (s == o);
            c_COND_GE:     cond_taken = (s == o);
            c_COND_LT:     cond_taken = (s != o);
            c_COND_LE:     cond_taken = z || (s != o);
            c_COND_HI:     cond_taken = c && !z;
            c_COND_LS:     cond_taken = !c || z;
            default:       cond_taken = 1'b0;
        endcase
    endfunction

    logic [0:0]  r_state;
    logic [2:0]  r_flush_cnt;
    logic        r_redirect_valid;
    logic [15:0] r_redirect_pc;
    logic        r_flush;
    logic [15:0] r_mis_cnt;

    logic        w_resolve;
    logic        w_taken;
    logic        w_mispredict;
    logic [15:0] w_target;
    logic [1:0]  w_fetch_ctr;
    logic        w_unused;

    assign w_resolve    = br_valid && !bubble && !stall && (r_state == c_ST_IDLE);
    assign w_taken      = cond_taken(br_cond, flags);
    assign w_mispredict = w_resolve && (w_taken != br_pred_taken);
    assign w_target     = br_pc + 16'd1 + br_imm;
    assign w_unused     = ^fetch_pc;

    branch_resolver_bht #(
        .BHT_BITS (BHT_BITS)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (fetch_pc[BHT_BITS-1:0]),
        .rd_ctr   (w_fetch_ctr),
        .wr_en    (w_resolve),
        .wr_idx   (br_pc[BHT_BITS-1:0]),
        .wr_taken (w_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= c_ST_IDLE;
            r_flush_cnt      <= 3'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 16'd0;
            r_flush          <= 1'b0;
            r_mis_cnt        <= 16'd0;
        end else if (!stall) begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_taken ? w_target : (br_pc + 16'd1);
                r_state       <= c_ST_FLUSH;
                r_flush_cnt   <= c_FLUSH_INIT;
                r_flush       <= 1'b1;
                if (r_mis_cnt != 16'hFFFF) begin
                    r_mis_cnt <= r_mis_cnt + 16'd1;
                end
            end else if (r_state == c_ST_FLUSH) begin
                if (r_flush_cnt == 3'd0) begin
                    r_state <= c_ST_IDLE;
                    r_flush <= 1'b0;
                end else begin
                    r_flush_cnt <= r_flush_cnt - 3'd1;
                end
            end
        end
    end

    assign fetch_pred_taken = w_fetch_ctr[1];
    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign flush            = r_flush;
    assign mispredict_count = r_mis_cnt;

endmodule

`default_nettype wire
